// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared types and phase-to-channel role table for the rainbow sequencer
// Purpose: sequencer state enum, colour-wheel constants and the per-phase
// channel role lookup used by the duty mapper.
// Ports: none (package).
package rgb_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // What a channel's duty is doing within one hue phase.
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    FULL = 2'd3
  } role_t;

  localparam int NUM_PHASES = 6;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  // Colour wheel: each phase has one channel at full, one ramping, one dark.
  // The ramping channel hands over seamlessly at phase edges (fall at lvl 0 == full).
  function automatic role_t channel_role(input logic [2:0] phase, input logic [1:0] ch);
    role_t r;
    r = ZERO;
    case (phase)
      3'd0: if (ch == CH_R) r = FULL; else if (ch == CH_G) r = RISE;
      3'd1: if (ch == CH_R) r = FALL; else if (ch == CH_G) r = FULL;
      3'd2: if (ch == CH_G) r = FULL; else if (ch == CH_B) r = RISE;
      3'd3: if (ch == CH_G) r = FALL; else if (ch == CH_B) r = FULL;
      3'd4: if (ch == CH_R) r = RISE; else if (ch == CH_B) r = FULL;
      3'd5: if (ch == CH_R) r = FULL; else if (ch == CH_B) r = FALL;
      default: r = ZERO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rgb_rainbow_sequencer_pwm_compare.sv
// rtl/rgb_rainbow_sequencer_pwm_compare.sv - registered active-low PWM comparator
// Purpose: drives one LED pin low while the shared period counter is below the duty.
// Ports:
//   CLK  in   system clock
//   RST  in   synchronous active-low reset (pin goes high = LED off)
//   cnt  in   shared period counter
//   duty in   shadowed duty for this channel
//   pwm  out  active-low LED drive, one cycle behind cnt
module pwm_compare #(
  parameter int CW = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] duty,
  output logic          pwm
);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pwm <= 1'b1;
    end else begin
      pwm <= (cnt < duty) ? 1'b0 : 1'b1;
    end
  end

endmodule

// File: rtl/rgb_rainbow_sequencer.sv
// rtl/rgb_rainbow_sequencer.sv - coordinated RGB hue-wheel PWM sequencer
// Purpose: one shared period counter, an OFF/RUN/HOLD scheduler walking a
// 6-phase colour wheel, boundary-shadowed duties and three PWM comparators.
// Ports:
//   CLK    in   system clock
//   RST    in   synchronous active-low reset
//   EN     in   run request (level)
//   STOP   in   return to OFF (level, wins over EN)
//   PWM_R  out  red drive, active-low
//   PWM_G  out  green drive, active-low
//   PWM_B  out  blue drive, active-low
//   PHASE  out  current hue phase 0..5
//   SYNC   out  pulse in the cycle where the period counter is 0
module rgb_rainbow_sequencer
  import rgb_pkg::*;
#(
  parameter int PERIOD       = 2450,
  parameter int STEP_PERIODS = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       STOP,
  output logic       PWM_R,
  output logic       PWM_G,
  output logic       PWM_B,
  output logic [2:0] PHASE,
  output logic       SYNC
);

  localparam int CW = $clog2(PERIOD + 1);
  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [CW-1:0] PER       = CW'(PERIOD);
  localparam logic [CW-1:0] LAST      = CW'(PERIOD - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIODS - 1);
  localparam logic [2:0]    PH_LAST   = 3'(NUM_PHASES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lvl, lvl_nxt;
  logic [2:0]    phase, phase_nxt;
  logic [SW-1:0] step_cnt, step_nxt;
  logic [CW-1:0] shadow_r, shadow_g, shadow_b;
  logic [CW-1:0] duty_r, duty_g, duty_b;
  logic          sync_q;
  logic          boundary, tick;

  function automatic logic [CW-1:0] role_value(input role_t role, input logic [CW-1:0] l);
    case (role)
      FULL:    return PER;
      RISE:    return l;
      FALL:    return PER - l;
      default: return '0;
    endcase
  endfunction

  assign boundary = (cnt == LAST);
  assign tick     = boundary && (step_cnt == STEP_LAST);

  always_comb begin
    state_nxt = state;
    lvl_nxt   = lvl;
    phase_nxt = phase;
    step_nxt  = step_cnt;

    case (state)
      OFF:     if (boundary && EN && !STOP) state_nxt = RUN;
      RUN:     if (STOP) state_nxt = OFF; else if (!EN) state_nxt = HOLD;
      HOLD:    if (STOP) state_nxt = OFF; else if (EN) state_nxt = RUN;
      default: state_nxt = OFF;
    endcase

    // The wheel only advances on cycles that stay in RUN; leaving RUN on a
    // tick freezes the position where it was.
    if (state_nxt == OFF) begin
      lvl_nxt   = '0;
      phase_nxt = '0;
      step_nxt  = '0;
    end else if (state == RUN && state_nxt == RUN && boundary) begin
      step_nxt = (step_cnt == STEP_LAST) ? '0 : step_cnt + SW'(1);
      if (tick) begin
        if (lvl == LAST) begin
          lvl_nxt   = '0;
          phase_nxt = (phase == PH_LAST) ? 3'd0 : phase + 3'd1;
        end else begin
          lvl_nxt = lvl + CW'(1);
        end
      end
    end
  end

  // Duties follow the next wheel position so a tick and its shadow load land
  // on the same boundary; OFF loads dark duties.
  always_comb begin
    duty_r = '0;
    duty_g = '0;
    duty_b = '0;
    if (state_nxt != OFF) begin
      duty_r = role_value(channel_role(phase_nxt, CH_R), lvl_nxt);
      duty_g = role_value(channel_role(phase_nxt, CH_G), lvl_nxt);
      duty_b = role_value(channel_role(phase_nxt, CH_B), lvl_nxt);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= OFF;
      cnt      <= '0;
      lvl      <= '0;
      phase    <= '0;
      step_cnt <= '0;
      shadow_r <= '0;
      shadow_g <= '0;
      shadow_b <= '0;
      sync_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= boundary ? '0 : cnt + CW'(1);
      lvl      <= lvl_nxt;
      phase    <= phase_nxt;
      step_cnt <= step_nxt;
      sync_q   <= boundary;
      if (boundary) begin
        shadow_r <= duty_r;
        shadow_g <= duty_g;
        shadow_b <= duty_b;
      end
    end
  end

  assign PHASE = phase;
  assign SYNC  = sync_q;

  pwm_compare #(.CW(CW)) u_pwm_r (.CLK(CLK), .RST(RST), .cnt(cnt), .duty(shadow_r), .pwm(PWM_R));
  pwm_compare #(.CW(CW)) u_pwm_g (.CLK(CLK), .RST(RST), .cnt(cnt), .duty(shadow_g), .pwm(PWM_G));
  pwm_compare #(.CW(CW)) u_pwm_b (.CLK(CLK), .RST(RST), .cnt(cnt), .duty(shadow_b), .pwm(PWM_B));

endmodule

// File: tb/tb_rgb_rainbow_sequencer.sv
// tb/tb_rgb_rainbow_sequencer.sv - scoreboard bench for rgb_rainbow_sequencer
module tb_rgb_rainbow_sequencer;

  localparam int P      = 8;
  localparam int STEPS  = 1;
  localparam int M_OFF  = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic       STOP = 1'b0;
  logic       PWM_R, PWM_G, PWM_B, SYNC;
  logic [2:0] PHASE;

  rgb_rainbow_sequencer #(.PERIOD(P), .STEP_PERIODS(STEPS)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .STOP(STOP),
    .PWM_R(PWM_R), .PWM_G(PWM_G), .PWM_B(PWM_B),
    .PHASE(PHASE), .SYNC(SYNC)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       r;
    logic       g;
    logic       b;
    logic [2:0] phase;
    logic       sync;
  } obs_t;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_cycle = 0;

  // Reference: wheel position pos = phase*P + lvl over 0..6P-1.
  int m_cnt = 0, m_mode = M_OFF, m_pos = 0, m_steps = 0;
  int m_sh[3];

  logic       s_r, s_g, s_b, s_sync;
  logic [2:0] s_phase;

  // Red's duty over the wheel; green and blue are the same shape rotated by
  // 2 and 4 phases.
  function automatic int r_shape(int p, int l);
    case (p)
      0, 5:    return P;
      1:       return P - l;
      4:       return l;
      default: return 0;
    endcase
  endfunction

  function automatic int hue_duty(int ch, int pos);
    return r_shape((pos / P - 2 * ch + 6) % 6, pos % P);
  endfunction

  task automatic model_edge(input logic rst, input logic en, input logic stop);
    obs_t e;
    int   nm;
    bit   bnd;
    if (!rst) begin
      m_cnt = 0; m_mode = M_OFF; m_pos = 0; m_steps = 0;
      for (int c = 0; c < 3; c++) m_sh[c] = 0;
      e = '{r: 1'b1, g: 1'b1, b: 1'b1, phase: 3'd0, sync: 1'b0};
    end else begin
      bnd    = (m_cnt == P - 1);
      e.r    = (m_cnt < m_sh[0]) ? 1'b0 : 1'b1;
      e.g    = (m_cnt < m_sh[1]) ? 1'b0 : 1'b1;
      e.b    = (m_cnt < m_sh[2]) ? 1'b0 : 1'b1;
      e.sync = bnd;
      if (m_mode == M_OFF) nm = (bnd && en && !stop) ? M_RUN : M_OFF;
      else                 nm = stop ? M_OFF : (en ? M_RUN : M_HOLD);
      if (nm == M_OFF) begin
        m_pos = 0; m_steps = 0;
      end else if (m_mode == M_RUN && nm == M_RUN && bnd) begin
        m_steps++;
        if (m_steps == STEPS) begin
          m_steps = 0;
          m_pos = (m_pos + 1) % (6 * P);
        end
      end
      if (bnd) for (int c = 0; c < 3; c++) m_sh[c] = (nm == M_OFF) ? 0 : hue_duty(c, m_pos);
      m_mode  = nm;
      m_cnt   = (m_cnt + 1) % P;
      e.phase = 3'(m_pos / P);
    end
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin : monitor
    obs_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{r: PWM_R, g: PWM_G, b: PWM_B, phase: PHASE, sync: SYNC};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard cycle %0d: actual rgb=%b%b%b phase=%0d sync=%b, required rgb=%b%b%b phase=%0d sync=%b",
                 mon_cycle, a.r, a.g, a.b, a.phase, a.sync, e.r, e.g, e.b, e.phase, e.sync);
      end
      mon_cycle++;
    end
  end

  // Samples DUT outputs left by the previous edge, then drives one cycle.
  task automatic step(input logic rst, input logic en, input logic stop);
    @(negedge CLK);
    s_r = PWM_R; s_g = PWM_G; s_b = PWM_B; s_phase = PHASE; s_sync = SYNC;
    RST = rst; EN = en; STOP = stop;
    @(posedge CLK);
    model_edge(rst, en, stop);
  endtask

  task automatic run_count(input int n, input logic en, input logic stop,
                           output int lr, output int lg, output int lb, output int ls);
    lr = 0; lg = 0; lb = 0; ls = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, en, stop);
      if (s_r == 1'b0) lr++;
      if (s_g == 1'b0) lg++;
      if (s_b == 1'b0) lb++;
      if (s_sync == 1'b1) ls++;
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name, input int limit);
    checks++;
    errors++;
    $display("FAIL %s: not reached within %0d cycles", name, limit);
  endtask

  task automatic wait_pos(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (!(m_mode == M_RUN && m_pos == target) && n < limit) begin
      step(1'b1, 1'b1, 1'b0);
      n++;
    end
    if (n >= limit) bound_fail(name, limit);
  endtask

  task automatic wait_run(input int limit, input string name);
    int n;
    n = 0;
    while (m_mode != M_RUN && n < limit) begin
      step(1'b1, 1'b1, 1'b0);
      n++;
    end
    if (n >= limit) bound_fail(name, limit);
  endtask

  task automatic wait_cnt(input int target, input logic en, input string name);
    int n;
    n = 0;
    while (m_cnt != target && n < 2 * P) begin
      step(1'b1, en, 1'b0);
      n++;
    end
    if (n >= 2 * P) bound_fail(name, 2 * P);
  endtask

  initial begin
    int lr, lg, lb, ls;

    // 1. reset, idle OFF
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_int("reset pins", {29'd0, s_r, s_g, s_b}, 7);
    check_int("reset phase", int'(s_phase), 0);
    check_int("reset sync", int'(s_sync), 0);
    run_count(16, 1'b0, 1'b0, lr, lg, lb, ls);
    check_int("off lows", lr + lg + lb, 0);
    check_int("off sync pulses", ls, 2);

    // 2. EN raised mid-period, start on boundary
    wait_cnt(3, 1'b0, "mid period");
    wait_run(2 * P, "start");
    run_count(1, 1'b1, 1'b0, lr, lg, lb, ls);
    run_count(P, 1'b1, 1'b0, lr, lg, lb, ls);
    check_int("period0 R lows", lr, P);
    check_int("period0 G lows", lg, 0);
    check_int("period0 B lows", lb, 0);

    // 3. ramp: period 3 of phase 0
    run_count(2 * P, 1'b1, 1'b0, lr, lg, lb, ls);
    run_count(P, 1'b1, 1'b0, lr, lg, lb, ls);
    check_int("period3 R lows", lr, P);
    check_int("period3 G lows", lg, 3);
    check_int("period3 B lows", lb, 0);

    // 4. hold at phase 2 lvl 5
    wait_pos(2 * P + 5, 40 * P, "phase2 lvl5");
    run_count(P, 1'b0, 1'b0, lr, lg, lb, ls);
    run_count(P, 1'b0, 1'b0, lr, lg, lb, ls);
    check_int("hold R lows", lr, 0);
    check_int("hold G lows", lg, P);
    check_int("hold B lows", lb, 5);
    check_int("hold phase", int'(s_phase), 2);
    run_count(17 * P, 1'b0, 1'b0, lr, lg, lb, ls);
    run_count(P, 1'b0, 1'b0, lr, lg, lb, ls);
    check_int("hold late G lows", lg, P);
    check_int("hold late B lows", lb, 5);
    wait_pos(2 * P + 6, 3 * P, "resume lvl6");
    run_count(1, 1'b1, 1'b0, lr, lg, lb, ls);
    run_count(P, 1'b1, 1'b0, lr, lg, lb, ls);
    check_int("resume B lows", lb, 6);

    // full wrap 5 -> 0, then STOP+EN in phase 4
    wait_pos(0, 50 * P * P, "wheel wrap");
    wait_pos(4 * P + 2, 50 * P * P, "phase4");
    wait_cnt(3, 1'b1, "phase4 mid");
    step(1'b1, 1'b1, 1'b1);
    run_count(2 * P, 1'b0, 1'b0, lr, lg, lb, ls);
    run_count(P, 1'b0, 1'b0, lr, lg, lb, ls);
    check_int("stopped lows", lr + lg + lb, 0);
    check_int("stopped phase", int'(s_phase), 0);

    // 6. reset mid-period in phase 3, restart with EN high
    wait_pos(3 * P + 2, 50 * P * P, "phase3");
    wait_cnt(4, 1'b1, "phase3 mid");
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_int("midrun reset pins", {29'd0, s_r, s_g, s_b}, 7);
    check_int("midrun reset phase", int'(s_phase), 0);
    wait_run(2 * P, "restart");
    run_count(1, 1'b1, 1'b0, lr, lg, lb, ls);
    run_count(P, 1'b1, 1'b0, lr, lg, lb, ls);
    check_int("restart R lows", lr, P);
    check_int("restart G lows", lg, 0);

    // randomized soak against the reference
    for (int i = 0; i < 2000; i++) begin
      logic r, e, s;
      r = ($urandom_range(0, 399) != 0);
      s = ($urandom_range(0, 79) == 0);
      e = ($urandom_range(0, 4) != 0);
      step(r, e, s);
    end

    step(1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
